ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Sequences all accesses to the single-port data RAM and shares it between two requesters: the CPU MEM stage (cpu_*) and the I/O loader / debug port (io_*).
- Each requester uses a level req / one-cycle ack handshake; the stage controller holds the pipeline while cpu_stall is high.
- Registers the RAM address, write data and write enable, and waits a parameterised read latency before returning read data.

Parameters:
ADDR_WIDTH, 16, RAM word-address width; matches the RAM address bit width.
DATA_WIDTH, 32, data width.
RAM_LATENCY, 1, cycles from address presented at RAM to ram_data valid; legal range 1..4.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
cpu_req  input  1  CPU access request; held high until cpu_ack.
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_addr  input  ADDR_WIDTH  CPU address; stable while cpu_req is high.
cpu_wdata  input  DATA_WIDTH  CPU write data.
cpu_ack  output  1  one-cycle completion pulse to the CPU.
cpu_rdata  output  DATA_WIDTH  read data; valid when cpu_ack is high after a read.
cpu_stall  output  1  cpu_req & ~cpu_ack (combinational).
io_req  input  1  I/O request; same rules as cpu_req.
io_we  input  1  I/O write select.
io_addr  input  ADDR_WIDTH  I/O address.
io_wdata  input  DATA_WIDTH  I/O write data.
io_ack  output  1  one-cycle completion pulse to I/O.
io_rdata  output  DATA_WIDTH  I/O read data.
ram_address  output  ADDR_WIDTH  registered RAM address.
ram_write_data  output  DATA_WIDTH  registered RAM write data.
ram_wren  output  1  registered RAM write enable.
ram_data  input  DATA_WIDTH  RAM read data.
busy  output  1  high when state != IDLE.

Behaviour:
- Interface: one clock (clk); reset (reset_n) is asynchronous and active-low.
- Reset values (while reset_n = 0, including mid-transaction):
  - state = IDLE; all acks, ram_wren and busy = 0.
  - ram_address, ram_write_data, cpu_rdata, io_rdata = 0.
  - wait counter = 0; last_grant = IO, so the CPU wins the first tie.
- An in-flight transaction is abandoned on reset and no ack is ever issued for it.
- States and transitions:
  - IDLE: if any req is high, choose the owner and register addr/wdata/we into ram_*. Go to ACCESS.
  - ACCESS (1 cycle): ram_wren = owner's we. A write goes to DONE; a read goes to WAIT with the counter loaded to RAM_LATENCY-1.
  - WAIT: decrement the counter each cycle. When the counter = 0, capture ram_data into the owner's rdata and go to DONE.
  - DONE (1 cycle): owner's ack = 1, ram_wren = 0, last_grant = owner. Next state is IDLE.
- Arbitration:
  - Only one requester high: grant it.
  - Both high in IDLE: grant the one that is not last_grant (round-robin).
  - A request arriving during a transaction waits; it is never lost.
- Latency, request sampled in IDLE at cycle 0:
  - Write: ram_wren high in cycle 1 only; ack in cycle 2.
  - Read: ack in cycle 2+RAM_LATENCY.
  - Minimum spacing between back-to-back grants is 3 cycles for writes.
- Handshake rules:
  - The requester deasserts req in the cycle after ack. A req seen in IDLE is always a new request.
  - req must stay high until ack; dropping it early gives undefined data, but the FSM still completes the access and pulses ack.
- ram_wren is never high outside ACCESS. ram_address and ram_write_data hold their value until the next grant.
- The non-owner's ack stays 0; its rdata holds its previous value.
- cpu_rdata and io_rdata change only on completion of that requester's own read.
- Only ADDR_WIDTH address bits are used; there is no wrap or bounds checking.

Test Plan:
1. After reset, CPU write addr 0x0010, data 0xDEADBEEF -> ram_wren = 1 only in cycle 1 with ram_address 0x0010; cpu_ack in cycle 2; io_ack stays 0.
2. CPU read 0x0010 with RAM_LATENCY = 1 after test 1 -> cpu_ack in cycle 3 with cpu_rdata = 0xDEADBEEF; cpu_stall high in cycles 0-2.
3. cpu_req and io_req rise in the same cycle from reset, both held -> CPU is served first, then I/O. Repeat the tie -> grants alternate CPU, IO, CPU.
4. I/O write 0x0005 = 0x12345678 while the CPU requests mid-transaction -> CPU is granted in the IDLE after io_ack; a CPU read of 0x0005 returns 0x12345678.
5. Assert reset_n = 0 during WAIT of a read -> all outputs 0 immediately with no clock needed; no ack afterwards; a fresh request after release completes normally.
6. RAM_LATENCY = 3 read -> ack in cycle 5; busy high in cycles 1-5 and low in cycle 6.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin sharing of a single-port data RAM between CPU and I/O requesters
module ram_access_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  io_req,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_ack,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  state_e                  state_q, state_d;
  logic                    owner_q, owner_d, last_q, last_d, wren_q, wren_d, grant_io;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
  // owner/last_grant encoding: 1 = I/O, 0 = CPU; a tie goes to whoever was not served last
  assign grant_io = io_req & (~cpu_req | ~last_q);
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wren_d      = wren_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    case (state_q)
      IDLE: if (cpu_req | io_req) begin
        state_d = ACCESS;
        owner_d = grant_io;
        addr_d  = grant_io ? io_addr : cpu_addr;
        wdata_d = grant_io ? io_wdata : cpu_wdata;
        wren_d  = grant_io ? io_we : cpu_we;
      end
      ACCESS: begin
        state_d = wren_q ? DONE : WAIT;
        wren_d  = 1'b0;
        cnt_d   = 3'(RAM_LATENCY - 1);
      end
      WAIT: begin
        cnt_d = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d     = DONE;
          cpu_rdata_d = owner_q ? cpu_rdata_q : ram_data;
          io_rdata_d  = owner_q ? ram_data : io_rdata_q;
        end
      end
      default: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      wren_q      <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wren_q      <= wren_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end
  assign cpu_ack        = (state_q == DONE) & ~owner_q;
  assign io_ack         = (state_q == DONE) & owner_q;
  assign cpu_stall      = cpu_req & ~cpu_ack;
  assign cpu_rdata      = cpu_rdata_q;
  assign io_rdata       = io_rdata_q;
  assign ram_address    = addr_q;
  assign ram_write_data = wdata_q;
  assign ram_wren       = wren_q;
  assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed checks of the RAM arbiter with a latency-1 RAM and a latency-3 pattern RAM
module tb_ram_access_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, io_req = 1'b0, io_we = 1'b0;
  logic [15:0] cpu_addr = '0, io_addr = '0;
  logic [31:0] cpu_wdata = '0, io_wdata = '0;
  logic        cpu_ack, cpu_stall, io_ack, ram_wren, busy;
  logic [31:0] cpu_rdata, io_rdata, ram_write_data, ram_data;
  logic [15:0] ram_address;
  logic [31:0] mem [0:255];
  logic        c3_req = 1'b0, c3_we = 1'b0, i3_req = 1'b0, i3_we = 1'b0;
  logic [15:0] c3_addr = '0, i3_addr = '0, ram_address3;
  logic [31:0] c3_wdata = '0, i3_wdata = '0;
  logic        c3_ack, c3_stall, i3_ack, ram_wren3, busy3;
  logic [31:0] c3_rdata, i3_rdata, ram_write_data3;
  logic [31:0] p3 [0:2];
  int          checks = 0, errors = 0;
  logic [1:0]  who;
  int          cyc;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RAM_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .ram_address(ram_address), .ram_write_data(ram_write_data), .ram_wren(ram_wren),
    .ram_data(ram_data), .busy(busy)
  );

  ram_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RAM_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
    .io_req(i3_req), .io_we(i3_we), .io_addr(i3_addr), .io_wdata(i3_wdata),
    .io_ack(i3_ack), .io_rdata(i3_rdata),
    .ram_address(ram_address3), .ram_write_data(ram_write_data3), .ram_wren(ram_wren3),
    .ram_data(p3[2]), .busy(busy3)
  );

  // Latency-1 synchronous RAM for dut; dut3 sees a 3-stage pipe of a fixed address pattern
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[7:0]] <= ram_write_data;
    ram_data <= mem[ram_address[7:0]];
    p3[0]    <= {16'hA5A5, ram_address3};
    p3[1]    <= p3[0];
    p3[2]    <= p3[1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    io_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_ack(output logic [1:0] w, output int c);
    w = 2'b00;
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack || io_ack) begin
        w = {io_ack, cpu_ack};
        c = i;
        break;
      end
      step();
    end
    step();
    if (w[0]) cpu_req = 1'b0;
    if (w[1]) io_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cpu_ack, io_ack, ram_wren, busy, cpu_stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ack, io_ack, ram_wren, busy, cpu_stall});
    end
    checks++;
    if ({ram_address, ram_write_data} !== 48'h0) begin
      errors++;
      $display("FAIL reset_ram_bus: got %h expected 0", {ram_address, ram_write_data});
    end
    checks++;
    if ({cpu_rdata, io_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", {cpu_rdata, io_rdata});
    end
    checks++;
    if ({busy3, c3_ack, ram_wren3} !== 3'b0) begin
      errors++;
      $display("FAIL reset_dut3: got %b expected 000", {busy3, c3_ack, ram_wren3});
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_write();
    logic [4:0] e;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = {c == 1, c == 2, 1'b0, c < 2, c == 1 || c == 2};
      checks++;
      if ({ram_wren, cpu_ack, io_ack, cpu_stall, busy} !== e) begin
        errors++;
        $display("FAIL write_cyc%0d wren/cack/iack/stall/busy: got %b expected %b", c,
                 {ram_wren, cpu_ack, io_ack, cpu_stall, busy}, e);
      end
      if (c == 1) begin
        checks++;
        if ({ram_address, ram_write_data} !== {16'h0010, 32'hDEADBEEF}) begin
          errors++;
          $display("FAIL write_bus: got %h expected 0010deadbeef", {ram_address, ram_write_data});
        end
      end
      step();
      if (c == 2) cpu_req = 1'b0;
    end
  endtask

  task automatic test_read();
    logic [3:0] e;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e = {1'b0, c == 3, c < 3, c >= 1 && c <= 3};
      checks++;
      if ({ram_wren, cpu_ack, cpu_stall, busy} !== e) begin
        errors++;
        $display("FAIL read_cyc%0d wren/ack/stall/busy: got %b expected %b", c,
                 {ram_wren, cpu_ack, cpu_stall, busy}, e);
      end
      if (c >= 3) begin
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL read_rdata_cyc%0d: got %h expected deadbeef", c, cpu_rdata);
        end
      end
      step();
      if (c == 3) cpu_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h1;
      io_req  = 1'b1; io_we  = 1'b1; io_addr  = 16'h0021; io_wdata  = 32'h2;
      wait_ack(who, cyc);
      checks++;
      if (who !== 2'b01 || cyc != 2) begin
        errors++;
        $display("FAIL tie%0d_first: got who=%b cyc=%0d expected who=01 cyc=2", r, who, cyc);
      end
      wait_ack(who, cyc);
      checks++;
      if (who !== 2'b10 || cyc != 2) begin
        errors++;
        $display("FAIL tie%0d_second: got who=%b cyc=%0d expected who=10 cyc=2", r, who, cyc);
      end
    end
    cpu_req = 1'b1;
    wait_ack(who, cyc);
    checks++;
    if (who !== 2'b01 || cyc != 2) begin
      errors++;
      $display("FAIL lone_cpu: got who=%b cyc=%0d expected who=01 cyc=2", who, cyc);
    end
    cpu_req = 1'b1;
    io_req  = 1'b1;
    wait_ack(who, cyc);
    checks++;
    if (who !== 2'b10 || cyc != 2) begin
      errors++;
      $display("FAIL rr_io_first: got who=%b cyc=%0d expected who=10 cyc=2", who, cyc);
    end
    wait_ack(who, cyc);
    checks++;
    if (who !== 2'b01 || cyc != 2) begin
      errors++;
      $display("FAIL rr_cpu_second: got who=%b cyc=%0d expected who=01 cyc=2", who, cyc);
    end
  endtask

  task automatic test_io_then_cpu();
    io_req = 1'b1; io_we = 1'b1; io_addr = 16'h0005; io_wdata = 32'h12345678;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    @(negedge clk);
    checks++;
    if ({ram_wren, ram_address, ram_write_data, cpu_stall} !== {1'b1, 16'h0005, 32'h12345678, 1'b1}) begin
      errors++;
      $display("FAIL io_write_bus: got %h expected %h", {ram_wren, ram_address, ram_write_data, cpu_stall},
               {1'b1, 16'h0005, 32'h12345678, 1'b1});
    end
    step();
    @(negedge clk);
    checks++;
    if ({io_ack, cpu_ack, cpu_stall} !== 3'b101) begin
      errors++;
      $display("FAIL io_ack_cpu_waits: got %b expected 101", {io_ack, cpu_ack, cpu_stall});
    end
    step();
    io_req = 1'b0;
    wait_ack(who, cyc);
    checks++;
    if (who !== 2'b01 || cyc != 3) begin
      errors++;
      $display("FAIL cpu_after_io: got who=%b cyc=%0d expected who=01 cyc=3", who, cyc);
    end
    checks++;
    if ({cpu_rdata, io_rdata} !== {32'h12345678, 32'h0}) begin
      errors++;
      $display("FAIL cpu_readback: got %h expected 1234567800000000", {cpu_rdata, io_rdata});
    end
  endtask

  task automatic test_async_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step();
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy: got %b expected 1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cpu_ack, io_ack, ram_wren, busy, ram_address, ram_write_data, cpu_rdata, io_rdata} !== 116'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0",
               {cpu_ack, io_ack, ram_wren, busy, ram_address, ram_write_data, cpu_rdata, io_rdata});
    end
    cpu_req = 1'b0;
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({cpu_ack, io_ack, busy} !== 3'b0) begin
        errors++;
        $display("FAIL no_ack_after_reset_cyc%0d: got %b expected 000", c, {cpu_ack, io_ack, busy});
      end
      step();
    end
    cpu_req = 1'b1; cpu_addr = 16'h0005;
    wait_ack(who, cyc);
    checks++;
    if (who !== 2'b01 || cyc != 3 || cpu_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL fresh_read: got who=%b cyc=%0d rdata=%h expected who=01 cyc=3 rdata=12345678",
               who, cyc, cpu_rdata);
    end
  endtask

  task automatic test_latency3();
    logic [3:0] e;
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 16'h0042;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e = {1'b0, c == 5, c < 5, c >= 1 && c <= 5};
      checks++;
      if ({ram_wren3, c3_ack, c3_stall, busy3} !== e) begin
        errors++;
        $display("FAIL lat3_cyc%0d wren/ack/stall/busy: got %b expected %b", c,
                 {ram_wren3, c3_ack, c3_stall, busy3}, e);
      end
      if (c == 5) begin
        checks++;
        if (c3_rdata !== 32'hA5A50042) begin
          errors++;
          $display("FAIL lat3_rdata: got %h expected a5a50042", c3_rdata);
        end
      end
      step();
      if (c == 5) c3_req = 1'b0;
    end
    checks++;
    if ({i3_ack, i3_rdata, ram_write_data3} !== 65'h0) begin
      errors++;
      $display("FAIL lat3_io_side: got %h expected 0", {i3_ack, i3_rdata, ram_write_data3});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_io_then_cpu();
    test_async_reset();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
